// File: rtl/gtech_barrier_pkg.sv
// Shared types and sizes for the 8-participant barrier.
package gtech_barrier_pkg;

  localparam int unsigned N_PART = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TMO_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/gtech_popcnt8.sv
// Combinational population count of an 8-bit vector.
module gtech_popcnt8
  import gtech_barrier_pkg::*;
(
  input  logic [N_PART-1:0] bits,
  output logic [CNT_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N_PART; i++) begin
      cnt = cnt + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/gtech_barrier8.sv
// Eight-participant arrival barrier with one-cycle release pulse.
// Optional round timeout enabled by defining GTECH_BARRIER8_TMO_EN.
module gtech_barrier8
  import gtech_barrier_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_PART-1:0] ARR,
  input  logic [N_PART-1:0] MASK,
  input  logic              CLR,
  output logic              REL,
  output logic [N_PART-1:0] PEND,
  output logic [CNT_W-1:0]  CNT,
  output logic              BUSY,
  output logic              TMO
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("gtech_barrier8: TIMEOUT must be in 1..255");
  end

  state_t            state, state_n;
  logic [N_PART-1:0] pend_n;
  logic [N_PART-1:0] nxt;
  logic              complete;
  logic              rel_n;
  logic              expire;

  assign nxt      = PEND | (ARR & MASK);
  assign complete = (&(nxt | ~MASK)) && (MASK != '0);

  // Priority: abort, disabled barrier, completion, timeout, then collection.
  always_comb begin
    state_n = state;
    pend_n  = PEND;
    rel_n   = 1'b0;
    if (CLR || MASK == '0) begin
      state_n = IDLE;
      pend_n  = '0;
    end else if (complete) begin
      state_n = DONE;
      pend_n  = '0;
      rel_n   = 1'b1;
    end else if (expire) begin
      state_n = IDLE;
      pend_n  = '0;
    end else if (nxt != '0) begin
      state_n = COLLECT;
      pend_n  = nxt;
    end else begin
      state_n = IDLE;
      pend_n  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      PEND  <= '0;
      REL   <= 1'b0;
    end else begin
      state <= state_n;
      PEND  <= pend_n;
      REL   <= rel_n;
    end
  end

`ifdef GTECH_BARRIER8_TMO_EN
  logic [TMO_W-1:0] tcnt;

  assign expire = (state == COLLECT) && (tcnt == TMO_W'(TIMEOUT));

  // Counter is 1 in the first COLLECT cycle, so it equals the number of COLLECT cycles seen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt <= '0;
      TMO  <= 1'b0;
    end else begin
      TMO <= !CLR && (MASK != '0) && !complete && expire;
      if (state_n == COLLECT) begin
        tcnt <= (state == COLLECT) ? tcnt + 1'b1 : TMO_W'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end
`else
  assign expire = 1'b0;
  assign TMO    = 1'b0;
`endif

  assign BUSY = (state == COLLECT);

  gtech_popcnt8 u_popcnt (
    .bits (PEND & MASK),
    .cnt  (CNT)
  );

endmodule

// File: tb/tb_gtech_barrier8.sv
// Directed self-checking bench for gtech_barrier8 (TIMEOUT overridden to 4).
module tb_gtech_barrier8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] ARR;
  logic [7:0] MASK;
  logic       CLR;
  logic       REL;
  logic [7:0] PEND;
  logic [3:0] CNT;
  logic       BUSY;
  logic       TMO;

  int n_checks = 0;
  int n_fail   = 0;

  gtech_barrier8 #(.TIMEOUT(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ARR  (ARR),
    .MASK (MASK),
    .CLR  (CLR),
    .REL  (REL),
    .PEND (PEND),
    .CNT  (CNT),
    .BUSY (BUSY),
    .TMO  (TMO)
  );

  always #5 CLK = ~CLK;

  // Packed view of all outputs: {REL, TMO, BUSY, CNT, PEND}
  function automatic logic [14:0] outs();
    return {REL, TMO, BUSY, CNT, PEND};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; ARR = '0; MASK = '0; CLR = 1'b0;
    #12;
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: outs=%h expected %h", outs(), 15'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_release: outs=%h expected %h", outs(), 15'h0);
    end
  endtask

  task automatic test_sequential();
    logic [14:0] exp;
    MASK = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      ARR = 8'(1 << i);
      step();
      if (i < 7) exp = {1'b0, 1'b0, 1'b1, 4'(i + 1), 8'((2 << i) - 1)};
      else       exp = {1'b1, 1'b0, 1'b0, 4'd0, 8'h00};
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL seq_arrival[%0d]: outs=%h expected %h", i, outs(), exp);
      end
    end
    ARR = '0;
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL seq_rel_one_cycle: outs=%h expected %h", outs(), 15'h0);
    end
  endtask

  task automatic test_single_edge();
    MASK = 8'h0F; ARR = 8'hFF;
    step();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL single_edge_rel: outs=%h expected %h", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    ARR = '0;
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL single_edge_idle: outs=%h expected %h", outs(), 15'h0);
    end
  endtask

  task automatic test_mask_change();
    MASK = 8'hFF; ARR = 8'h7F;
    step();
    n_checks++;
    if (outs() !== {1'b0, 1'b0, 1'b1, 4'd7, 8'h7F}) begin
      n_fail++;
      $display("FAIL mask_pend7f: outs=%h expected %h", outs(), {1'b0, 1'b0, 1'b1, 4'd7, 8'h7F});
    end
    MASK = 8'h7F; ARR = 8'h00;
    step();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL mask_drop_rel: outs=%h expected %h", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    MASK = 8'h00; ARR = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (outs() !== 15'h0) begin
        n_fail++;
        $display("FAIL mask_zero[%0d]: outs=%h expected %h", i, outs(), 15'h0);
      end
    end
    ARR = '0;
  endtask

  task automatic test_clr_and_reset();
    MASK = 8'hFF; ARR = 8'h3F;
    step();
    n_checks++;
    if (PEND !== 8'h3F) begin
      n_fail++;
      $display("FAIL clr_setup: PEND=%h expected 3f", PEND);
    end
    ARR = 8'hC0; CLR = 1'b1;
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL clr_override: outs=%h expected %h", outs(), 15'h0);
    end
    CLR = 1'b0; ARR = 8'h0F;
    step();
    n_checks++;
    if (outs() !== {1'b0, 1'b0, 1'b1, 4'd4, 8'h0F}) begin
      n_fail++;
      $display("FAIL rst_setup: outs=%h expected %h", outs(), {1'b0, 1'b0, 1'b1, 4'd4, 8'h0F});
    end
    ARR = '0;
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL rst_async: outs=%h expected %h", outs(), 15'h0);
    end
    #1 RST = 1'b0;
    step();
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL rst_discard: outs=%h expected %h", outs(), 15'h0);
    end
  endtask

  task automatic test_back_to_back();
    MASK = 8'hFF; ARR = 8'hFF;
    step();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL b2b_first_rel: outs=%h expected %h", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    ARR = 8'h01;
    step();
    n_checks++;
    if (outs() !== {1'b0, 1'b0, 1'b1, 4'd1, 8'h01}) begin
      n_fail++;
      $display("FAIL b2b_capture_in_done: outs=%h expected %h", outs(), {1'b0, 1'b0, 1'b1, 4'd1, 8'h01});
    end
    ARR = 8'hFE;
    step();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL b2b_second_rel: outs=%h expected %h", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    ARR = 8'hFF;
    step();
    n_checks++;
    if (outs() !== {1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL b2b_done_to_done: outs=%h expected %h", outs(), {1'b1, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    ARR = '0;
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL b2b_idle: outs=%h expected %h", outs(), 15'h0);
    end
  endtask

  task automatic test_timeout();
    MASK = 8'hFF; ARR = 8'h01;
    step();
    ARR = '0;
`ifdef GTECH_BARRIER8_TMO_EN
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outs() !== {1'b0, 1'b0, 1'b1, 4'd1, 8'h01}) begin
        n_fail++;
        $display("FAIL tmo_collect[%0d]: outs=%h expected %h", i, outs(), {1'b0, 1'b0, 1'b1, 4'd1, 8'h01});
      end
      step();
    end
    n_checks++;
    if (outs() !== {1'b0, 1'b0, 1'b1, 4'd1, 8'h01}) begin
      n_fail++;
      $display("FAIL tmo_fourth: outs=%h expected %h", outs(), {1'b0, 1'b0, 1'b1, 4'd1, 8'h01});
    end
    step();
    n_checks++;
    if (outs() !== {1'b0, 1'b1, 1'b0, 4'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL tmo_pulse: outs=%h expected %h", outs(), {1'b0, 1'b1, 1'b0, 4'd0, 8'h00});
    end
    step();
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL tmo_one_cycle: outs=%h expected %h", outs(), 15'h0);
    end
`else
    for (int i = 0; i < 300; i++) begin
      n_checks++;
      if (outs() !== {1'b0, 1'b0, 1'b1, 4'd1, 8'h01}) begin
        n_fail++;
        $display("FAIL no_tmo[%0d]: outs=%h expected %h", i, outs(), {1'b0, 1'b0, 1'b1, 4'd1, 8'h01});
      end
      step();
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    n_checks++;
    if (outs() !== 15'h0) begin
      n_fail++;
      $display("FAIL no_tmo_clr: outs=%h expected %h", outs(), 15'h0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_single_edge();
    test_mask_change();
    test_clr_and_reset();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
